// File: rtl/uart_tx_queue_if.sv
// Bus bundle between host decode, the TX queue and the uart register port.
// The queue itself uses the slave view; the surrounding system drives the master view.
interface uart_tx_queue_if;
  logic       h_cs;
  logic       h_we;
  logic       h_addr;
  logic [7:0] h_dbw;
  logic [7:0] h_dbr;
  logic       u_cs;
  logic       u_we;
  logic       u_addr;
  logic [7:0] u_dbw;
  logic [7:0] u_dbr;

  modport slave (
    input  h_cs, h_we, h_addr, h_dbw, u_dbr,
    output h_dbr, u_cs, u_we, u_addr, u_dbw
  );

  modport master (
    output h_cs, h_we, h_addr, h_dbw, u_dbr,
    input  h_dbr, u_cs, u_we, u_addr, u_dbw
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Host-side TX FIFO that drains into the uart data register whenever the uart
// status (reg 1, bit 7) reports ready, polling with a back-off gap while busy.
module uart_tx_queue #(
  parameter int DEPTH    = 16,
  parameter int POLL_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_queue_if.slave   bus_io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_WAIT, S_BACK, S_WRITE, S_GAP
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    h_dbr_q, h_dbr_d;
  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          u_cs_q, u_cs_d, u_we_q, u_we_d, u_addr_q, u_addr_d;
  logic [7:0]    u_dbw_q, u_dbw_d;

  logic full, empty, host_wr, host_rd, status_rd, push, drop, pop;
  logic [7:0] status;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign host_wr   = bus_io.h_cs & bus_io.h_we & ~bus_io.h_addr;
  assign host_rd   = bus_io.h_cs & ~bus_io.h_we;
  assign status_rd = host_rd & bus_io.h_addr;
  // Full is judged before any same-cycle pop, so a push on full is always dropped.
  assign push      = host_wr & ~full;
  assign drop      = host_wr & full;
  assign pop       = (state_q == S_WRITE);
  assign status    = {full, empty, ovf_q, 5'(count_q)};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    h_dbr_d  = h_dbr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (host_rd)   h_dbr_d = bus_io.h_addr ? status : 8'h00;
    if (status_rd) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_POLL;
      S_POLL:  state_d = S_WAIT;
      S_WAIT: begin
        if (bus_io.u_dbr[7]) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_BACK;
          gap_d   = GW'(POLL_GAP);
        end
      end
      S_BACK: begin
        if (gap_q == '0) state_d = S_POLL;
        else             gap_d   = gap_q - GW'(1);
      end
      S_WRITE: state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered from the next state so they coincide with POLL/WRITE.
    u_cs_d   = (state_d == S_POLL) || (state_d == S_WRITE);
    u_we_d   = (state_d == S_WRITE);
    u_addr_d = (state_d == S_POLL);
    u_dbw_d  = (state_d == S_WRITE) ? mem_q[rd_ptr_q] : u_dbw_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus_io.h_dbw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      h_dbr_q  <= 8'h00;
      state_q  <= S_IDLE;
      gap_q    <= '0;
      u_cs_q   <= 1'b0;
      u_we_q   <= 1'b0;
      u_addr_q <= 1'b0;
      u_dbw_q  <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      h_dbr_q  <= h_dbr_d;
      state_q  <= state_d;
      gap_q    <= gap_d;
      u_cs_q   <= u_cs_d;
      u_we_q   <= u_we_d;
      u_addr_q <= u_addr_d;
      u_dbw_q  <= u_dbw_d;
    end
  end

  assign bus_io.h_dbr  = h_dbr_q;
  assign bus_io.u_cs   = u_cs_q;
  assign bus_io.u_we   = u_we_q;
  assign bus_io.u_addr = u_addr_q;
  assign bus_io.u_dbw  = u_dbw_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed + randomized bench for uart_tx_queue against a byte-queue reference model.
module tb_uart_tx_queue;
  localparam int DEPTH    = 16;
  localparam int POLL_GAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_queue_if bus();
  logic       uart_rdy = 1'b0;
  logic [6:0] junk     = 7'h00;
  assign bus.u_dbr = {uart_rdy, junk};

  uart_tx_queue #(.DEPTH(DEPTH), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst(rst), .bus_io(bus)
  );

  int checks = 0, passed = 0, fails = 0;
  int cyc = 0;
  logic [7:0] model_q[$];
  int acc = 0, pops = 0;
  bit pend = 0, ovf_m = 0;
  bit is_wait = 0, prev_poll = 0, last_resp = 0, prev_strobe = 0;
  int polls = 0, writes = 0;
  int poll_cyc[$];
  int last_write_cyc = -1, last_poll_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: capture the uart response the DUT samples, then observe outputs.
  task automatic tick();
    logic poll_now, wr_now;
    @(posedge clk);
    if (is_wait) last_resp = bus.u_dbr[7];
    @(negedge clk);
    cyc++;
    if (pend) pops++;
    pend = 0;
    junk = 7'($urandom);
    poll_now = bus.u_cs & ~bus.u_we & bus.u_addr;
    wr_now   = bus.u_cs & bus.u_we;
    is_wait   = prev_poll;
    prev_poll = poll_now;
    if (bus.u_cs) chk("strobe_one_cycle", prev_strobe, 0);
    prev_strobe = bus.u_cs;
    if (poll_now) begin
      polls++;
      last_poll_cyc = cyc;
      poll_cyc.push_back(cyc);
    end
    if (wr_now) begin
      writes++;
      last_write_cyc = cyc;
      pend = 1;
      chk("write_after_ready", last_resp, 1);
      chk("write_expected", model_q.size() > 0, 1);
      if (model_q.size() > 0) chk("write_byte", bus.u_dbw, model_q.pop_front());
    end
  endtask

  task automatic host_write(input logic [7:0] b);
    bus.h_cs = 1; bus.h_we = 1; bus.h_addr = 0; bus.h_dbw = b;
    if (acc - pops < DEPTH) begin
      model_q.push_back(b);
      acc++;
    end else begin
      ovf_m = 1;
    end
    tick();
    bus.h_cs = 0; bus.h_we = 0;
  endtask

  task automatic host_read(input logic addr, input string tag, output logic [7:0] v);
    int sz;
    logic [7:0] e;
    sz = acc - pops;
    e = addr ? {sz == DEPTH, sz == 0, ovf_m, 5'(sz)} : 8'h00;
    bus.h_cs = 1; bus.h_we = 0; bus.h_addr = addr;
    tick();
    bus.h_cs = 0; bus.h_addr = 0;
    if (addr) ovf_m = 0;
    v = bus.h_dbr;
    chk(tag, v, e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000 && (model_q.size() != 0 || pend); i++) tick();
    repeat (12) tick();
    chk(tag, model_q.size(), 0);
  endtask

  initial begin
    logic [7:0] v;
    int c0, p0, w0;
    bus.h_cs = 0; bus.h_we = 0; bus.h_addr = 0; bus.h_dbw = 0;
    repeat (2) tick();
    rst = 0;
    chk("rst_u_cs", bus.u_cs, 0);
    chk("rst_u_we", bus.u_we, 0);
    chk("rst_u_addr", bus.u_addr, 0);
    chk("rst_u_dbw", bus.u_dbw, 0);
    chk("rst_h_dbr", bus.h_dbr, 0);
    host_read(1, "rst_status", v);
    chk("rst_status_const", v, 8'h40);

    // Single byte with uart ready: POLL then WRITE on fixed latency.
    uart_rdy = 1;
    p0 = polls;
    w0 = writes;
    host_write(8'h7B);
    c0 = cyc;
    repeat (8) tick();
    chk("t1_poll_count", polls - p0, 1);
    chk("t1_poll_cycle", last_poll_cyc, c0 + 1);
    chk("t1_write_cycle", last_write_cyc, c0 + 3);
    chk("t1_write_count", writes - w0, 1);
    host_read(1, "t1_status", v);
    chk("t1_status_const", v, 8'h40);
    host_read(0, "t1_data_reg_read", v);

    // Busy uart for three polls, then two writes in order.
    uart_rdy = 0;
    poll_cyc.delete();
    p0 = polls;
    w0 = writes;
    host_write(8'h3E);
    host_write(8'hFF);
    for (int i = 0; i < 200 && polls - p0 < 4; i++) tick();
    chk("t2_polls_reached", polls - p0 >= 4, 1);
    chk("t2_no_write_busy", writes - w0, 0);
    uart_rdy = 1;
    if (poll_cyc.size() >= 4)
      for (int i = 1; i < 4; i++) chk("t2_poll_spacing", poll_cyc[i] - poll_cyc[i-1], POLL_GAP + 3);
    drain("t2_drain");
    chk("t2_write_count", writes - w0, 2);

    // Overflow: fill while busy, drop the 17th byte, ovf clears on read.
    uart_rdy = 0;
    for (int i = 0; i < DEPTH; i++) host_write(8'(i));
    host_read(1, "t3_status_full", v);
    chk("t3_status_full_const", v, 8'h90);
    host_write(8'd16);
    host_read(1, "t3_status_ovf", v);
    chk("t3_status_ovf_const", v, 8'hB0);
    host_read(1, "t3_status_cleared", v);
    chk("t3_status_cleared_const", v, 8'h90);
    w0 = writes;
    uart_rdy = 1;
    drain("t3_drain");
    chk("t3_write_count", writes - w0, DEPTH);
    host_read(1, "t3_status_end", v);

    // Push coinciding with a WRITE pop at count 5, then random traffic across the wrap.
    uart_rdy = 0;
    for (int i = 0; i < 5; i++) host_write(8'($urandom));
    uart_rdy = 1;
    for (int i = 0; i < 100 && !pend; i++) tick();
    chk("t4_write_seen", pend, 1);
    host_write(8'($urandom));
    host_read(1, "t4_status", v);
    chk("t4_status_const", v, 8'h05);
    for (int i = 0; i < 40; i++) begin
      uart_rdy = ($urandom_range(0, 3) != 0);
      host_write(8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    uart_rdy = 1;
    drain("t4_drain");
    host_read(1, "t4_status_end", v);

    // Reset while waiting on a poll response with bytes queued.
    uart_rdy = 0;
    for (int i = 0; i < 3; i++) host_write(8'hC0 + 8'(i));
    for (int i = 0; i < 100 && !is_wait; i++) tick();
    chk("t5_wait_seen", is_wait, 1);
    rst = 1;
    tick();
    rst = 0;
    model_q.delete();
    acc = 0; pops = 0; pend = 0; ovf_m = 0;
    prev_poll = 0; is_wait = 0;
    chk("t5_u_cs", bus.u_cs, 0);
    chk("t5_u_we", bus.u_we, 0);
    chk("t5_u_addr", bus.u_addr, 0);
    chk("t5_u_dbw", bus.u_dbw, 0);
    host_read(1, "t5_status", v);
    chk("t5_status_const", v, 8'h40);
    w0 = writes;
    uart_rdy = 1;
    repeat (20) tick();
    chk("t5_no_write", writes - w0, 0);
    host_write(8'hA5);
    drain("t5_drain");
    chk("t5_one_write", writes - w0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
